// File: rtl/equiv_stim_sequencer_if.sv
`timescale 1ns/1ps
// Control, result and DUT-facing signals of the equivalence stimulus sequencer.
// The sequencer connects through the slave modport; the controlling side uses master.
interface equiv_stim_sequencer_if #(
  parameter int unsigned IN_W  = 57,
  parameter int unsigned OUT_W = 605
);
  logic             start;
  logic             abort;
  logic [31:0]      exp_sig;
  logic [OUT_W-1:0] dut_y;
  logic [IN_W-1:0]  dut_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [15:0]      vec_idx;
  logic [31:0]      signature;

  modport master (
    output start, abort, exp_sig, dut_y,
    input  dut_in, busy, done, pass, fail, vec_idx, signature
  );

  modport slave (
    input  start, abort, exp_sig, dut_y,
    output dut_in, busy, done, pass, fail, vec_idx, signature
  );
endinterface

// File: rtl/equiv_stim_sequencer.sv
`timescale 1ns/1ps
// Drives LFSR vectors into the equivalence-test netlist, waits a settle time per vector,
// folds the wide response into a 32-bit MISR and compares the final value against exp_sig.
module equiv_stim_sequencer #(
  parameter int unsigned IN_W    = 57,
  parameter int unsigned OUT_W   = 605,
  parameter int unsigned NUM_VEC = 20,
  parameter int unsigned SETTLE  = 0,
  parameter logic [63:0] SEED    = 64'h1,
  parameter logic [31:0] POLY    = 32'h04C11DB7
) (
  input logic                   clk,
  input logic                   rst,
  equiv_stim_sequencer_if.slave bus
);
  localparam int          NWORDS   = int'((OUT_W + 32'd31) / 32'd32);
  localparam logic [63:0] SEED_V   = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 32'd1);
  localparam logic [7:0]  SETTLE_V = 8'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] fold_y(input logic [OUT_W-1:0] y);
    logic [NWORDS*32-1:0] ext;
    logic [31:0]          acc;
    ext            = '0;
    ext[OUT_W-1:0] = y;
    acc            = 32'd0;
    for (int i = 0; i < NWORDS; i++) begin
      acc = acc ^ ext[i*32 +: 32];
    end
    return acc;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] word);
    return {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'd0) ^ word;
  endfunction

  // Taps 64,63,61,60 (1-based); a non-zero state never reaches zero.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  state_e          state_q, state_d;
  logic [63:0]     lfsr_q, lfsr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IN_W-1:0] dut_in_q, dut_in_d;
  logic [31:0]     sig_q, sig_d;
  logic [15:0]     vec_idx_q, vec_idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;

  // Next-state and next-output logic of the run controller.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    dut_in_d  = dut_in_q;
    sig_d     = sig_q;
    vec_idx_d = vec_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          dut_in_d  = lfsr_q[IN_W-1:0];
          lfsr_d    = lfsr_step(lfsr_q);
          sig_d     = 32'hFFFF_FFFF;
          vec_idx_d = 16'd0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = SETTLE_V;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          sig_d = misr_step(sig_q, fold_y(bus.dut_y));
          if (vec_idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            dut_in_d  = lfsr_q[IN_W-1:0];
            lfsr_d    = lfsr_step(lfsr_q);
            vec_idx_d = vec_idx_q + 16'd1;
            cnt_d     = SETTLE_V;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (!bus.abort) begin
          pass_d = (sig_q == bus.exp_sig);
          fail_d = (sig_q != bus.exp_sig);
        end else begin
          pass_d = 1'b0;
          fail_d = 1'b0;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED_V;
      cnt_q     <= 8'd0;
      dut_in_q  <= '0;
      sig_q     <= 32'd0;
      vec_idx_q <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      dut_in_q  <= dut_in_d;
      sig_q     <= sig_d;
      vec_idx_q <= vec_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.vec_idx   = vec_idx_q;
  assign bus.signature = sig_q;
endmodule

// File: tb/tb_equiv_stim_sequencer.sv
`timescale 1ns/1ps
// Directed bench: u_a runs single-vector signature checks from a table, u_b covers
// settle timing, abort, start filtering, LFSR continuation and mid-run reset.
module tb_equiv_stim_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  equiv_stim_sequencer_if #(.IN_W(57), .OUT_W(605)) ifa ();
  equiv_stim_sequencer_if #(.IN_W(57), .OUT_W(605)) ifb ();

  equiv_stim_sequencer #(.NUM_VEC(1), .SETTLE(0), .SEED(64'h1)) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  equiv_stim_sequencer #(.NUM_VEC(20), .SETTLE(2), .SEED(64'h0)) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  typedef struct {
    logic [604:0] y;
    logic [31:0]  exp_sig;
    logic [56:0]  din;
    logic [31:0]  sig;
    logic         pass;
    logic         fail;
  } vec_t;

  vec_t        tbl [5];
  logic [63:0] lfsr_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  initial begin
    int c;
    bit sent;
    n_checks = 0;
    n_fail   = 0;

    tbl[0] = '{y: '0,                            exp_sig: 32'hFB3EE249, din: 57'h1,
               sig: 32'hFB3EE249, pass: 1'b1, fail: 1'b0};
    tbl[1] = '{y: '1,                            exp_sig: 32'hFB3EE249, din: 57'h2,
               sig: 32'hE4C11DB6, pass: 1'b0, fail: 1'b1};
    tbl[2] = '{y: 605'd1,                        exp_sig: 32'hFB3EE248, din: 57'h4,
               sig: 32'hFB3EE248, pass: 1'b1, fail: 1'b0};
    tbl[3] = '{y: (605'd1 << 32) | 605'd1,       exp_sig: 32'h0,        din: 57'h8,
               sig: 32'hFB3EE249, pass: 1'b0, fail: 1'b1};
    tbl[4] = '{y: 605'd1 << 604,                 exp_sig: 32'hEB3EE249, din: 57'h10,
               sig: 32'hEB3EE249, pass: 1'b1, fail: 1'b0};

    rst = 1'b1;
    ifa.start = 1'b1; ifa.abort = 1'b0; ifa.exp_sig = 32'h0; ifa.dut_y = '0;
    ifb.start = 1'b1; ifb.abort = 1'b0; ifb.exp_sig = 32'h0; ifb.dut_y = '0;
    tick();
    tick();
    chk("rst_a_busy", 64'(ifa.busy), 64'd0);
    chk("rst_a_done", 64'(ifa.done), 64'd0);
    chk("rst_a_pass", 64'(ifa.pass), 64'd0);
    chk("rst_a_fail", 64'(ifa.fail), 64'd0);
    chk("rst_a_dut_in", 64'(ifa.dut_in), 64'd0);
    chk("rst_a_vec_idx", 64'(ifa.vec_idx), 64'd0);
    chk("rst_a_sig", 64'(ifa.signature), 64'd0);
    chk("rst_b_busy", 64'(ifb.busy), 64'd0);
    chk("rst_b_sig", 64'(ifb.signature), 64'd0);
    rst = 1'b0; ifa.start = 1'b0; ifb.start = 1'b0;
    tick();
    chk("post_rst_a_busy", 64'(ifa.busy), 64'd0);
    chk("post_rst_b_busy", 64'(ifb.busy), 64'd0);

    // Single-vector runs: signature after one MISR step from all-ones.
    for (int i = 0; i < 5; i++) begin
      ifa.dut_y = tbl[i].y;
      ifa.exp_sig = tbl[i].exp_sig;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      chk("tbl_busy", 64'(ifa.busy), 64'd1);
      chk("tbl_dut_in", 64'(ifa.dut_in), 64'(tbl[i].din));
      chk("tbl_sig_init", 64'(ifa.signature), 64'hFFFFFFFF);
      chk("tbl_clr_pass", 64'(ifa.pass), 64'd0);
      chk("tbl_clr_fail", 64'(ifa.fail), 64'd0);
      chk("tbl_done_early", 64'(ifa.done), 64'd0);
      tick();
      chk("tbl_done", 64'(ifa.done), 64'd1);
      chk("tbl_busy_done", 64'(ifa.busy), 64'd0);
      chk("tbl_sig", 64'(ifa.signature), 64'(tbl[i].sig));
      tick();
      chk("tbl_done_off", 64'(ifa.done), 64'd0);
      chk("tbl_pass", 64'(ifa.pass), 64'(tbl[i].pass));
      chk("tbl_fail", 64'(ifa.fail), 64'(tbl[i].fail));
    end

    // Walk the generator through its feedback taps, one run per vector.
    lfsr_m = 64'h20;
    ifa.dut_y = '0;
    ifa.exp_sig = 32'hFB3EE249;
    for (int r = 0; r < 70; r++) begin
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      chk("sweep_dut_in", 64'(ifa.dut_in), {7'd0, lfsr_m[56:0]});
      lfsr_m = lfsr_next(lfsr_m);
      tick();
      tick();
      chk("sweep_pass", 64'(ifa.pass), 64'd1);
    end

    // 20 vectors with 2 settle cycles: apply every 3 cycles, done at +60.
    ifb.dut_y = '1;
    ifb.exp_sig = 32'h0;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int k = 0; k <= 61; k++) begin
      int v;
      v = (k / 3 > 19) ? 19 : k / 3;
      chk("run_busy", 64'(ifb.busy), 64'(k < 60));
      chk("run_done", 64'(ifb.done), 64'(k == 60));
      chk("run_vec_idx", 64'(ifb.vec_idx), 64'(v));
      chk("run_dut_in", 64'(ifb.dut_in), 64'd1 << v);
      tick();
    end
    chk("run_verdict", 64'(ifb.pass ^ ifb.fail), 64'd1);

    // Second run: a start at vec_idx 2 is ignored, abort at vec_idx 5.
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    chk("run2_first_vec", 64'(ifb.dut_in), 64'd1 << 20);
    c = 0;
    sent = 1'b0;
    while (ifb.vec_idx != 16'd5 && c < 40) begin
      if (ifb.vec_idx == 16'd2 && !sent) begin
        ifb.start = 1'b1;
        sent = 1'b1;
      end else begin
        ifb.start = 1'b0;
      end
      tick();
      c++;
    end
    ifb.start = 1'b0;
    chk("abort_reach_cycle", 64'(c), 64'd15);
    chk("abort_pre_dut_in", 64'(ifb.dut_in), 64'd1 << 25);
    ifb.abort = 1'b1;
    tick();
    ifb.abort = 1'b0;
    chk("abort_busy", 64'(ifb.busy), 64'd0);
    chk("abort_done", 64'(ifb.done), 64'd0);
    chk("abort_vec_idx", 64'(ifb.vec_idx), 64'd5);
    chk("abort_dut_in", 64'(ifb.dut_in), 64'd1 << 25);
    chk("abort_pass", 64'(ifb.pass), 64'd0);
    chk("abort_fail", 64'(ifb.fail), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_no_done", 64'(ifb.done), 64'd0);
      chk("abort_idle", 64'(ifb.busy), 64'd0);
    end

    // start with abort in IDLE starts nothing.
    ifb.start = 1'b1;
    ifb.abort = 1'b1;
    tick();
    ifb.start = 1'b0;
    ifb.abort = 1'b0;
    chk("start_abort_busy", 64'(ifb.busy), 64'd0);
    chk("start_abort_dut_in", 64'(ifb.dut_in), 64'd1 << 25);
    tick();
    chk("start_abort_busy2", 64'(ifb.busy), 64'd0);

    // Third run continues the LFSR; reset it mid-run.
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    chk("run3_first_vec", 64'(ifb.dut_in), 64'd1 << 26);
    chk("run3_busy", 64'(ifb.busy), 64'd1);
    repeat (10) tick();
    chk("run3_vec_idx", 64'(ifb.vec_idx), 64'd3);
    chk("run3_dut_in", 64'(ifb.dut_in), 64'd1 << 29);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(ifb.busy), 64'd0);
    chk("midrst_dut_in", 64'(ifb.dut_in), 64'd0);
    chk("midrst_vec_idx", 64'(ifb.vec_idx), 64'd0);
    chk("midrst_sig", 64'(ifb.signature), 64'd0);
    chk("midrst_a_pass", 64'(ifa.pass), 64'd0);
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    chk("reseed_dut_in", 64'(ifb.dut_in), 64'd1);
    chk("reseed_busy", 64'(ifb.busy), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/equiv_stim_sequencer.md
Name: equiv_stim_sequencer

Overview:
Self-checking stimulus sequencer and response compactor for a generated equivalence-test `top` netlist. It drives pseudo-random vectors onto the DUT inputs {wire0, wire1, wire2, wire3} and waits a programmable settle time per vector. It then folds the wide DUT output `y` into a 32-bit MISR signature and compares the final signature against an expected value. This replaces the fixed vector list and per-cycle `$strobe` dump with a synthesizable run/compare controller.

Parameters:
IN_W, 57, DUT input width; dut_in maps to {wire0[12:0], wire1[17:0], wire2[20:0], wire3[4:0]}
OUT_W, 605, DUT output width (y)
NUM_VEC, 20, vectors per run, range 1..65535
SETTLE, 0, extra wait cycles per vector beyond the 1-cycle DUT register latency, range 0..255
SEED, 64'h1, LFSR seed; 0 is replaced by 64'h1
POLY, 32'h04C11DB7, MISR feedback polynomial

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  terminate a run; wins over start
exp_sig  in  32  expected final signature; sampled at the done edge
dut_y  in  OUT_W  DUT output y
dut_in  out  IN_W  DUT input vector, registered
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion
pass  out  1  final signature == exp_sig; held until next start
fail  out  1  final signature != exp_sig; held until next start
vec_idx  out  16  index of the vector currently applied
signature  out  32  current MISR value

Behaviour:
- Reset: state IDLE; busy=0, done=0, pass=0, fail=0, dut_in=0, vec_idx=0, signature=0, lfsr=SEED (or 1 if SEED=0), settle counter=0.
- States: IDLE, WAIT, DONE.
- IDLE, start=1 and abort=0 at edge E:
  - dut_in <= lfsr[IN_W-1:0]; lfsr advances one step.
  - signature <= 32'hFFFFFFFF; vec_idx <= 0; pass <= 0; fail <= 0; busy <= 1.
  - counter <= SETTLE; state -> WAIT.
- WAIT, counter>0: counter decrements each edge.
- WAIT, counter==0: capture edge.
  - signature <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(dut_y).
  - If vec_idx==NUM_VEC-1: state -> DONE.
  - Otherwise, on the same edge: next vector loaded to dut_in, lfsr advances, vec_idx+1, counter <= SETTLE.
- Timing: vector k is applied at edge E+k*(SETTLE+1) and its response is captured at edge E+(k+1)*(SETTLE+1).
- DONE state lasts exactly one cycle:
  - done=1 and busy=0 for that cycle.
  - Result register update at the edge leaving DONE: pass <= (signature==exp_sig), fail <= !pass.
  - state -> IDLE.
- done rises at edge E+NUM_VEC*(SETTLE+1); pass/fail are valid the following cycle.
- fold(dut_y): zero-extend to a multiple of 32 bits (605 -> 608, 19 words) and XOR all 32-bit words.
- LFSR: 64-bit Fibonacci, taps 64,63,61,60, shift left, new bit into bit 0. It never reaches 0. It continues across runs and re-seeds only on rst.
- abort=1 while busy (WAIT or DONE): state -> IDLE next edge.
  - busy <= 0; no done pulse; pass and fail stay 0.
  - dut_in, signature and vec_idx hold their values.
- start while busy: ignored.
- start and abort together in IDLE: no run starts.
- rst mid-run: returns all outputs to reset values on that edge, including lfsr.
- dut_in changes only at apply edges.

Test Plan:
1. rst=1 for 2 cycles -> all outputs 0, signature=0; start held during reset starts nothing.
2. SEED=1, NUM_VEC=1, SETTLE=0, dut_y=0, exp_sig=32'hFB3EE249, start at edge E -> dut_in=57'h1 after E; done pulse at E+1; pass=1, fail=0.
3. Same setup but dut_y all ones -> fold=32'h1FFFFFFF, signature=32'hE4C11DB6; with exp_sig=32'hFB3EE249 -> fail=1, pass=0.
4. NUM_VEC=20, SETTLE=2 -> dut_in changes every 3 cycles; vec_idx counts 0..19; done exactly 60 cycles after the start edge; busy high for exactly 60 cycles.
5. abort asserted at vec_idx=5 -> busy=0 next edge, no done, pass=fail=0; start asserted during the run before the abort is ignored (vec_idx not reset).
6. Back-to-back runs with identical dut_y behaviour -> second run's dut_in sequence continues the LFSR rather than repeating the first run; start and abort asserted together in IDLE -> busy stays 0.
